// File: rtl/dmem_lsu_if.sv
// Controller-to-memory bus for the data memory: single port, no byte enables,
// read data valid one cycle after a read.
interface dmem_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
);
  logic                  ena;
  logic                  web;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic [DATA_WIDTH-1:0] dout;

  modport master (output ena, web, addr, din, input dout);
  modport slave  (input ena, web, addr, din, output dout);
endinterface

// File: rtl/dmem_lsu.sv
// RV64 load/store unit in front of a doubleword-wide data memory; sub-doubleword
// stores are done as read-modify-write. Define DMEM_LSU_MISALIGN_CHK_EN to trap misaligned accesses.
//   state    | meaning
//   IDLE     | waiting for a request, req_ready high
//   RD       | memory read issued
//   RDWAIT   | read data returned; extract load lane or merge store bytes
//   WR       | memory write issued
//   RESP     | one-cycle response pulse
module dmem_lsu #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [63:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  dmem_if.master                mem
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_RDWAIT, S_WR, S_RESP} state_t;

  state_t                  state_q, state_d;
  logic                    we_q, we_d;
  logic [2:0]              funct3_q, funct3_d;
  logic [2:0]              off_q, off_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic                    err_q, err_d;
  logic                    mem_web_q, mem_web_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_din_q, mem_din_d;

  logic                    accept;
  logic                    illegal;
  logic                    misalign;
  logic [2:0]              req_off;
  logic [5:0]              shamt;
  logic [DATA_WIDTH-1:0]   lane;
  logic [DATA_WIDTH-1:0]   lane_mask;
  logic [DATA_WIDTH-1:0]   load_ext;
  logic [DATA_WIDTH-1:0]   merged;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^req_addr[63:ADDR_WIDTH+3];

  function automatic logic [DATA_WIDTH-1:0] size_mask(input logic [1:0] sz);
    logic [DATA_WIDTH-1:0] m;
    case (sz)
      2'd0:    m = {{(DATA_WIDTH-8){1'b0}},  {8{1'b1}}};
      2'd1:    m = {{(DATA_WIDTH-16){1'b0}}, {16{1'b1}}};
      2'd2:    m = {{(DATA_WIDTH-32){1'b0}}, {32{1'b1}}};
      default: m = '1;
    endcase
    return m;
  endfunction

  assign illegal = (req_funct3 == 3'b111) || (req_we && req_funct3[2]);

`ifdef DMEM_LSU_MISALIGN_CHK_EN
  always_comb begin
    case (req_funct3[1:0])
      2'd1:    misalign = req_addr[0];
      2'd2:    misalign = |req_addr[1:0];
      2'd3:    misalign = |req_addr[2:0];
      default: misalign = 1'b0;
    endcase
  end
  assign req_off = req_addr[2:0];
`else
  // Without trapping, the offset is rounded down to the access size.
  assign misalign = 1'b0;
  assign req_off  = req_addr[2:0] & (3'b111 << req_funct3[1:0]);
`endif

  assign accept    = req_valid && req_ready;
  assign shamt     = {off_q, 3'b000};
  assign lane      = mem.dout >> shamt;
  assign lane_mask = size_mask(funct3_q[1:0]) << shamt;
  assign merged    = (mem.dout & ~lane_mask) | ((wdata_q << shamt) & lane_mask);

  always_comb begin
    case (funct3_q)
      3'b000:  load_ext = {{(DATA_WIDTH-8){lane[7]}},   lane[7:0]};
      3'b001:  load_ext = {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
      3'b010:  load_ext = {{(DATA_WIDTH-32){lane[31]}}, lane[31:0]};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}},      lane[7:0]};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}},     lane[15:0]};
      3'b110:  load_ext = {{(DATA_WIDTH-32){1'b0}},     lane[31:0]};
      default: load_ext = lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      off_q      <= 3'b000;
      wdata_q    <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
      mem_web_q  <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      funct3_q   <= funct3_d;
      off_q      <= off_d;
      wdata_q    <= wdata_d;
      result_q   <= result_d;
      err_q      <= err_d;
      mem_web_q  <= mem_web_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
    end
  end

  // Memory-side registers only move on entry to RD/WR so they hold while idle.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    off_d      = off_q;
    wdata_d    = wdata_q;
    result_d   = result_q;
    err_d      = err_q;
    mem_web_d  = mem_web_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          off_d    = req_off;
          wdata_d  = req_wdata;
          result_d = '0;
          err_d    = illegal || misalign;
          if (illegal || misalign) begin
            state_d = S_RESP;
          end else if (!req_we || (req_funct3[1:0] != 2'b11)) begin
            state_d    = S_RD;
            mem_web_d  = 1'b0;
            mem_addr_d = req_addr[ADDR_WIDTH+2:3];
          end else begin
            state_d    = S_WR;
            mem_web_d  = 1'b1;
            mem_addr_d = req_addr[ADDR_WIDTH+2:3];
            mem_din_d  = req_wdata;
          end
        end
      end
      S_RD:     state_d = S_RDWAIT;
      S_RDWAIT: begin
        if (!we_q) begin
          result_d = load_ext;
          state_d  = S_RESP;
        end else begin
          mem_web_d = 1'b1;
          mem_din_d = merged;
          state_d   = S_WR;
        end
      end
      S_WR:     state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // rst gates the strobes so nothing escapes during a reset cycle.
  always_comb begin
    req_ready = rst && (state_q == S_IDLE);
    rsp_valid = rst && (state_q == S_RESP);
    rsp_err   = rst && (state_q == S_RESP) && err_q;
    rsp_rdata = (rst && (state_q == S_RESP)) ? result_q : '0;
    mem.ena   = rst && ((state_q == S_RD) || (state_q == S_WR));
    mem.web   = mem_web_q;
    mem.addr  = mem_addr_q;
    mem.din   = mem_din_q;
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed cases plus randomized traffic against a byte-level reference model.
module tb_dmem_lsu;
  localparam int AW = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  always #5 clk = ~clk;

  dmem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(64)) mem_bus ();

  dmem_lsu #(.ADDR_WIDTH(AW), .DATA_WIDTH(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem        (mem_bus)
  );

  logic [63:0] ram     [0:1023];
  logic [63:0] ref_mem [0:1023];
  logic        pk_en = 1'b0;
  logic [AW-1:0] pk_idx;
  logic [63:0] pk_val;

  always @(posedge clk) begin
    if (pk_en) ram[pk_idx] <= pk_val;
    else if (mem_bus.ena) begin
      if (mem_bus.web) ram[mem_bus.addr] <= mem_bus.din;
      else             mem_bus.dout <= ram[mem_bus.addr];
    end
  end

  typedef struct {
    logic          ena;
    logic          web;
    logic [AW-1:0] addr;
    logic [63:0]   din;
    logic          rv;
    logic          err;
    logic [63:0]   rdata;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   chk_idle = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t e_idle();
    exp_t e;
    e.ena = 0; e.web = 0; e.addr = '0; e.din = '0; e.rv = 0; e.err = 0; e.rdata = '0;
    return e;
  endfunction
  function automatic exp_t e_read(input logic [AW-1:0] a);
    exp_t e = e_idle();
    e.ena = 1; e.addr = a;
    return e;
  endfunction
  function automatic exp_t e_write(input logic [AW-1:0] a, input logic [63:0] d);
    exp_t e = e_idle();
    e.ena = 1; e.web = 1; e.addr = a; e.din = d;
    return e;
  endfunction
  function automatic exp_t e_resp(input logic er, input logic [63:0] d);
    exp_t e = e_idle();
    e.rv = 1; e.err = er; e.rdata = d;
    return e;
  endfunction

  // Per-cycle expectations for one accepted request, derived from byte semantics.
  task automatic model_req(input logic we, input logic [2:0] f3, input logic [63:0] a,
                           input logic [63:0] wd, output int lat);
    int            n;
    int            off;
    logic [AW-1:0] idx;
    logic          is_err;
    logic [63:0]   val;
    logic [63:0]   nw;
    n   = 1 << f3[1:0];
    off = int'(a[2:0]);
    idx = a[AW+2:3];
    is_err = (f3 == 3'd7) || (we && f3[2]);
`ifdef DMEM_LSU_MISALIGN_CHK_EN
    if ((off % n) != 0) is_err = 1'b1;
`else
    off = off - (off % n);
`endif
    if (is_err) begin
      exp_q.push_back(e_resp(1'b1, 64'd0));
      lat = 1;
    end else if (!we) begin
      val = '0;
      for (int i = 0; i < n; i++) val[8*i +: 8] = ref_mem[idx][8*(off+i) +: 8];
      if (!f3[2] && n < 8 && val[8*n-1])
        for (int i = n; i < 8; i++) val[8*i +: 8] = 8'hFF;
      exp_q.push_back(e_read(idx));
      exp_q.push_back(e_idle());
      exp_q.push_back(e_resp(1'b0, val));
      lat = 3;
    end else if (n == 8) begin
      exp_q.push_back(e_write(idx, wd));
      exp_q.push_back(e_resp(1'b0, 64'd0));
      ref_mem[idx] = wd;
      lat = 2;
    end else begin
      nw = ref_mem[idx];
      for (int i = 0; i < n; i++) nw[8*(off+i) +: 8] = wd[8*i +: 8];
      exp_q.push_back(e_read(idx));
      exp_q.push_back(e_idle());
      exp_q.push_back(e_write(idx, nw));
      exp_q.push_back(e_resp(1'b0, 64'd0));
      ref_mem[idx] = nw;
      lat = 4;
    end
  endtask

  logic          prev_ok = 1'b0;
  logic          prev_web;
  logic [AW-1:0] prev_addr;
  logic [63:0]   prev_din;

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("mem_ena", mem_bus.ena, e.ena);
      if (e.ena) begin
        chk("mem_web", mem_bus.web, e.web);
        chk("mem_addr", 64'(mem_bus.addr), 64'(e.addr));
        if (e.web) chk("mem_din", mem_bus.din, e.din);
      end
      chk("rsp_valid", rsp_valid, e.rv);
      if (e.rv) begin
        chk("rsp_err", rsp_err, e.err);
        chk("rsp_rdata", rsp_rdata, e.rdata);
      end
    end else if (chk_idle) begin
      chk("idle_ena", mem_bus.ena, 1'b0);
      chk("idle_rsp", rsp_valid, 1'b0);
    end
    if (rst && prev_ok && !mem_bus.ena) begin
      chk("hold_web", mem_bus.web, prev_web);
      chk("hold_addr", 64'(mem_bus.addr), 64'(prev_addr));
      chk("hold_din", mem_bus.din, prev_din);
    end
    prev_ok   = rst;
    prev_web  = mem_bus.web;
    prev_addr = mem_bus.addr;
    prev_din  = mem_bus.din;
  end

  task automatic poke(input int idx, input logic [63:0] v);
    pk_idx = AW'(idx);
    pk_val = v;
    pk_en  = 1'b1;
    ref_mem[idx] = v;
    @(posedge clk);
    #1 pk_en = 1'b0;
    @(negedge clk);
  endtask

  // Starts at a negedge, returns at the negedge of the response cycle.
  task automatic send(input logic we, input logic [2:0] f3, input logic [63:0] a,
                      input logic [63:0] wd, output logic [63:0] rd, output logic er,
                      output int lat);
    int w;
    int exp_lat;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    w = 0;
    while (!req_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    rd = '0; er = 1'b0; lat = 0;
    if (!req_ready) begin
      chk("accept_timeout", 64'(w), 64'd0);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    model_req(we, f3, a, wd, exp_lat);
    req_valid = 1'b0;
    req_we = $urandom_range(0, 1); req_funct3 = 3'($urandom);
    req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 10);
    rd = rsp_rdata;
    er = rsp_err;
    chk("latency", 64'(lat), 64'(exp_lat));
  endtask

  task automatic reset_during_wr();
    logic [63:0] v0;
    int          d;
    v0 = {$urandom, $urandom};
    poke(5, v0);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 64'd43; req_wdata = 64'h5A;
    chk("rst_test_ready", req_ready, 1'b1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    exp_q.push_back(e_read(AW'(5)));
    repeat (4) exp_q.push_back(e_idle());
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_in_rst", req_ready, 1'b0);
    chk("ena_in_rst", mem_bus.ena, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1'b1);
    @(negedge clk);
    chk("rst_mem_kept", ram[5], v0);
    d = 0;
    while (exp_q.size() > 0 && d < 5) begin
      @(negedge clk);
      d++;
    end
  endtask

  initial begin
    logic [63:0] rd;
    logic        er;
    int          lat;
    int          diffs;
    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    req_valid = 1'b1;
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 64'd0);
    chk("rst_mem_ena", mem_bus.ena, 1'b0);
    chk("rst_mem_web", mem_bus.web, 1'b0);
    chk("rst_mem_addr", 64'(mem_bus.addr), 64'd0);
    chk("rst_mem_din", mem_bus.din, 64'd0);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("ready_out_of_rst", req_ready, 1'b1);
    for (int i = 0; i < 16; i++) poke(i, {$urandom, $urandom});
    chk_idle = 1'b1;

    poke(2, 64'h1122334455667788);
    send(1'b0, 3'b011, 64'h10, 64'd0, rd, er, lat);
    chk("ld_rdata", rd, 64'h1122334455667788);
    chk("ld_err", er, 1'b0);
    chk("ld_lat", 64'(lat), 64'd3);

    poke(0, 64'h000000000000F080);
    send(1'b0, 3'b000, 64'h0, 64'd0, rd, er, lat);
    chk("lb", rd, 64'hFFFFFFFFFFFFFF80);
    send(1'b0, 3'b100, 64'h0, 64'd0, rd, er, lat);
    chk("lbu", rd, 64'h80);
    send(1'b0, 3'b001, 64'h0, 64'd0, rd, er, lat);
    chk("lh", rd, 64'hFFFFFFFFFFFFF080);
    send(1'b0, 3'b110, 64'h0, 64'd0, rd, er, lat);
    chk("lwu", rd, 64'h000000000000F080);

    poke(1, 64'hFFFFFFFFFFFFFFFF);
    send(1'b1, 3'b001, 64'h0A, 64'h1234, rd, er, lat);
    chk("sh_lat", 64'(lat), 64'd4);
    chk("sh_mem", ram[1], 64'hFFFFFFFF1234FFFF);

    send(1'b1, 3'b011, 64'h08, 64'hA5, rd, er, lat);
    chk("sd_lat", 64'(lat), 64'd2);
    chk("sd_mem", ram[1], 64'hA5);

    send(1'b0, 3'b111, 64'h08, 64'd0, rd, er, lat);
    chk("f3_111_err", er, 1'b1);
    chk("f3_111_lat", 64'(lat), 64'd1);
    send(1'b1, 3'b100, 64'h08, 64'd0, rd, er, lat);
    chk("store_u_err", er, 1'b1);

    poke(0, 64'h7654321081234567);
    send(1'b0, 3'b010, 64'h2, 64'd0, rd, er, lat);
`ifdef DMEM_LSU_MISALIGN_CHK_EN
    chk("lw_mis_err", er, 1'b1);
    chk("lw_mis_lat", 64'(lat), 64'd1);
`else
    chk("lw_mis_err", er, 1'b0);
    chk("lw_mis_rdata", rd, 64'hFFFFFFFF81234567);
`endif

    reset_during_wr();

    for (int k = 0; k < 400; k++) begin
      logic [63:0] a;
      a = {$urandom, $urandom};
      a[12:3] = 10'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, {$urandom, $urandom},
           rd, er, lat);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    diffs = 0;
    for (int i = 0; i < 1024; i++) if (ram[i] !== ref_mem[i]) diffs++;
    chk("mem_final", 64'(diffs), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
